textlcd_responder: RTL and testbench

// - HD44780-style character LCD responder: the display end of the rs/rw/en/data[7:0] bus.
// - Decodes instructions, holds 80-byte DDRAM and address counter (AC), answers reads, models busy time.
// - Used as the on-chip/bench display model for the text LCD writer; exposes DDRAM and protocol-error flags.

---
 rtl/textlcd_pkg.sv | 72 +++++++
 rtl/textlcd_ddram.sv | 43 ++++
 rtl/textlcd_responder.sv | 212 +++++++++++++++++++++
 tb/tb_textlcd_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/textlcd_pkg.sv
// rtl/textlcd_pkg.sv - shared constants, types and address helpers for the text LCD responder
package textlcd_pkg;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_CLR,
        CLS_HOME,
        CLS_ENTRY,
        CLS_DISP,
        CLS_SHIFT,
        CLS_FUNC,
        CLS_CGA,
        CLS_DDA
    } instr_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_FILL
    } lcd_state_e;

    localparam logic [6:0] LINE0_BASE    = 7'h00;
    localparam logic [6:0] LINE1_BASE    = 7'h40;
    localparam int         LINE_LEN      = 40;
    localparam int         DDRAM_DEPTH   = 80;
    localparam logic [7:0] SPACE_CODE    = 8'h20;
    // Index returned for an AC that does not map onto DDRAM; the RAM reads it back as a space.
    localparam logic [6:0] INVALID_INDEX = 7'h7F;

    localparam logic [6:0] LINE0_LAST    = LINE0_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE1_LAST    = LINE1_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] ONE_LINE_LAST = 7'(DDRAM_DEPTH - 1);

    // Instruction class is selected by the highest set bit of the command byte.
    function automatic instr_cls_e instr_class(input logic [7:0] d);
        if (d[7]) return CLS_DDA;
        if (d[6]) return CLS_CGA;
        if (d[5]) return CLS_FUNC;
        if (d[4]) return CLS_SHIFT;
        if (d[3]) return CLS_DISP;
        if (d[2]) return CLS_ENTRY;
        if (d[1]) return CLS_HOME;
        if (d[0]) return CLS_CLR;
        return CLS_NOP;
    endfunction

    function automatic logic [6:0] ac_index(input logic [6:0] a, input logic two_line);
        if (two_line) begin
            if (a < 7'(LINE_LEN)) return a - LINE0_BASE;
            if (a >= LINE1_BASE && a <= LINE1_LAST) return a - LINE1_BASE + 7'(LINE_LEN);
            return INVALID_INDEX;
        end
        if (a <= ONE_LINE_LAST) return a;
        return INVALID_INDEX;
    endfunction

    // Valid addresses wrap between line ends; invalid ones simply count mod 128.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic two_line,
                                           input logic inc);
        if (two_line) begin
            if (inc && a == LINE0_LAST)  return LINE1_BASE;
            if (inc && a == LINE1_LAST)  return LINE0_BASE;
            if (!inc && a == LINE0_BASE) return LINE1_LAST;
            if (!inc && a == LINE1_BASE) return LINE0_LAST;
        end else begin
            if (inc && a == ONE_LINE_LAST) return LINE0_BASE;
            if (!inc && a == LINE0_BASE)   return ONE_LINE_LAST;
        end
        return inc ? a + 7'd1 : a - 7'd1;
    endfunction

endpackage

// File: rtl/textlcd_ddram.sv
// rtl/textlcd_ddram.sv - 80x8 display RAM, one write port, two registered read ports
// Ports: clk, resetn (async active-low, clears read registers only); wr_en/wr_addr/wr_data
// write port; rd_a_addr/rd_a_data and rd_b_addr/rd_b_data read ports (1-cycle latency,
// indices above 79 read as a space).
module textlcd_ddram
    import textlcd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_a_addr,
    output logic [7:0] rd_a_data,
    input  logic [6:0] rd_b_addr,
    output logic [7:0] rd_b_data
);

    logic [7:0] mem [DDRAM_DEPTH];
    logic [7:0] rd_a_q;
    logic [7:0] rd_b_q;

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_addr <= ONE_LINE_LAST) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_a_q <= 8'h00;
            rd_b_q <= 8'h00;
        end else begin
            rd_a_q <= (rd_a_addr <= ONE_LINE_LAST) ? mem[rd_a_addr] : SPACE_CODE;
            rd_b_q <= (rd_b_addr <= ONE_LINE_LAST) ? mem[rd_b_addr] : SPACE_CODE;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;

endmodule

// File: rtl/textlcd_responder.sv
// rtl/textlcd_responder.sv - HD44780-style character LCD responder (display end of the bus)
// Ports: clk, resetn (async active-low); lcd_rs/lcd_rw/lcd_en/lcd_data_in bus inputs,
// lcd_data_out/lcd_data_oe read drive; rd_addr/rd_data debug DDRAM port; ac, busy,
// disp_on/cur_on/blink_on, entry_id, func_dl/func_n state; err_busy/err_addr sticky errors.
module textlcd_responder
    import textlcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 100,
    parameter int CLEAR_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] ac,
    output logic       busy,
    output logic       disp_on,
    output logic       cur_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       func_dl,
    output logic       func_n,
    output logic       err_busy,
    output logic       err_addr
);

    lcd_state_e  state_q, state_d;
    logic        en_s1_q, en_s2_q, en_s3_q;
    logic        cmd_rs_q, cmd_rw_q;
    logic [7:0]  cmd_data_q;
    logic [6:0]  ac_q, ac_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q;
    logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic        entry_q, entry_d, dl_q, dl_d, n_q, n_d;
    logic        err_busy_q, err_busy_d, err_addr_q, err_addr_d;
    logic [6:0]  fill_idx_q, fill_idx_d;

    logic        en_fall;
    logic [6:0]  cur_index;
    logic        mem_we;
    logic [6:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  bus_rd_data;

    assign en_fall   = en_s3_q & ~en_s2_q;
    assign cur_index = ac_index(ac_q, n_q);

    textlcd_ddram u_ddram (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (mem_we),
        .wr_addr   (mem_waddr),
        .wr_data   (mem_wdata),
        .rd_a_addr (rd_addr),
        .rd_a_data (rd_data),
        .rd_b_addr (cur_index),
        .rd_b_data (bus_rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            en_s1_q    <= 1'b0;
            en_s2_q    <= 1'b0;
            en_s3_q    <= 1'b0;
            cmd_rs_q   <= 1'b0;
            cmd_rw_q   <= 1'b0;
            cmd_data_q <= 8'h00;
            ac_q       <= 7'h00;
            cnt_q      <= 16'd0;
            busy_q     <= 1'b0;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blink_q    <= 1'b0;
            entry_q    <= 1'b1;
            dl_q       <= 1'b1;
            n_q        <= 1'b0;
            err_busy_q <= 1'b0;
            err_addr_q <= 1'b0;
            fill_idx_q <= 7'h00;
        end else begin
            state_q    <= state_d;
            en_s1_q    <= lcd_en;
            en_s2_q    <= en_s1_q;
            en_s3_q    <= en_s2_q;
            if (state_q == ST_IDLE && en_fall) begin
                cmd_rs_q   <= lcd_rs;
                cmd_rw_q   <= lcd_rw;
                cmd_data_q <= lcd_data_in;
            end
            ac_q       <= ac_d;
            cnt_q      <= cnt_d;
            busy_q     <= (cnt_d != 16'd0);
            disp_q     <= disp_d;
            cur_q      <= cur_d;
            blink_q    <= blink_d;
            entry_q    <= entry_d;
            dl_q       <= dl_d;
            n_q        <= n_d;
            err_busy_q <= err_busy_d;
            err_addr_q <= err_addr_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ac_d       = ac_q;
        cnt_d      = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        disp_d     = disp_q;
        cur_d      = cur_q;
        blink_d    = blink_q;
        entry_d    = entry_q;
        dl_d       = dl_q;
        n_d        = n_q;
        err_busy_d = err_busy_q;
        err_addr_d = err_addr_q;
        fill_idx_d = fill_idx_q;
        mem_we     = 1'b0;
        mem_waddr  = fill_idx_q;
        mem_wdata  = SPACE_CODE;

        case (state_q)
            ST_IDLE: begin
                if (en_fall) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (cmd_rw_q) begin
                    // Status reads have no side effect; data reads advance AC.
                    if (cmd_rs_q) ac_d = ac_step(ac_q, n_q, entry_q);
                end else if (busy_q) begin
                    err_busy_d = 1'b1;
                end else begin
                    cnt_d = 16'(BUSY_CYCLES);
                    if (cmd_rs_q) begin
                        if (cur_index != INVALID_INDEX) begin
                            mem_we    = 1'b1;
                            mem_waddr = cur_index;
                            mem_wdata = cmd_data_q;
                        end else begin
                            err_addr_d = 1'b1;
                        end
                        ac_d = ac_step(ac_q, n_q, entry_q);
                    end else begin
                        case (instr_class(cmd_data_q))
                            CLS_CLR: begin
                                cnt_d      = 16'(CLEAR_CYCLES);
                                ac_d       = LINE0_BASE;
                                entry_d    = 1'b1;
                                fill_idx_d = 7'h00;
                                state_d    = ST_FILL;
                            end
                            CLS_HOME: begin
                                cnt_d = 16'(CLEAR_CYCLES);
                                ac_d  = LINE0_BASE;
                            end
                            CLS_ENTRY: entry_d = cmd_data_q[1];
                            CLS_DISP: begin
                                disp_d  = cmd_data_q[2];
                                cur_d   = cmd_data_q[1];
                                blink_d = cmd_data_q[0];
                            end
                            CLS_SHIFT: begin
                                if (!cmd_data_q[3]) ac_d = ac_step(ac_q, n_q, cmd_data_q[2]);
                            end
                            CLS_FUNC: begin
                                dl_d = cmd_data_q[4];
                                n_d  = cmd_data_q[3];
                            end
                            CLS_DDA: ac_d = cmd_data_q[6:0];
                            default: ;
                        endcase
                    end
                end
            end
            ST_FILL: begin
                mem_we     = 1'b1;
                fill_idx_d = fill_idx_q + 7'd1;
                if (fill_idx_q == ONE_LINE_LAST) state_d = ST_IDLE;
                // The clear busy time covers the whole fill, so any write here is a busy violation.
                if (en_fall) begin
                    if (!lcd_rw) err_busy_d = 1'b1;
                    else if (lcd_rs) ac_d = ac_step(ac_q, n_q, entry_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lcd_data_oe  = en_s2_q & lcd_rw;
    assign lcd_data_out = lcd_data_oe ? (lcd_rs ? bus_rd_data : {busy_q, ac_q}) : 8'h00;

    assign ac       = ac_q;
    assign busy     = busy_q;
    assign disp_on  = disp_q;
    assign cur_on   = cur_q;
    assign blink_on = blink_q;
    assign entry_id = entry_q;
    assign func_dl  = dl_q;
    assign func_n   = n_q;
    assign err_busy = err_busy_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_textlcd_responder.sv
// tb/tb_textlcd_responder.sv - self-checking bench for textlcd_responder
`timescale 1ns/1ps
module tb_textlcd_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] lcd_data_out, rd_data;
    logic       lcd_data_oe, busy, disp_on, cur_on, blink_on, entry_id, func_dl, func_n;
    logic       err_busy, err_addr;
    logic [6:0] ac;

    textlcd_responder #(.BUSY_CYCLES(100), .CLEAR_CYCLES(3000)) dut (
        .clk(clk), .resetn(resetn), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac), .busy(busy), .disp_on(disp_on),
        .cur_on(cur_on), .blink_on(blink_on), .entry_id(entry_id), .func_dl(func_dl),
        .func_n(func_n), .err_busy(err_busy), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_mem [80];
    int         m_ac;
    bit         m_n, m_inc, m_dl, m_disp, m_cur, m_blink, m_err_addr, m_err_busy;
    logic [7:0] rdv;
    logic       oev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: DDRAM viewed as a ring of 80 cells; 2-line mode places cells 40..79 at 0x40.
    function automatic int m_index(input int a, input bit n);
        if (n) begin
            if (a < 40) return a;
            if (a >= 64 && a < 104) return a - 24;
            return -1;
        end
        return (a < 80) ? a : -1;
    endfunction

    function automatic int m_addr_of(input int idx, input bit n);
        return (n && idx >= 40) ? idx + 24 : idx;
    endfunction

    function automatic int m_step(input int a, input bit n, input bit inc);
        int idx;
        idx = m_index(a, n);
        if (idx < 0) return (a + (inc ? 1 : 127)) % 128;
        return m_addr_of((idx + (inc ? 1 : 79)) % 80, n);
    endfunction

    task automatic m_reset();
        m_ac = 0; m_n = 0; m_inc = 1; m_dl = 1;
        m_disp = 0; m_cur = 0; m_blink = 0; m_err_addr = 0; m_err_busy = 0;
    endtask

    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d,
                        output logic [7:0] rd, output logic oe);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        rd = lcd_data_out;
        oe = lcd_data_oe;
        lcd_en = 1'b0;
        repeat (5) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic do_instr(input logic [7:0] d);
        xfer(1'b0, 1'b0, d, rdv, oev);
        if (d[7]) m_ac = int'(d[6:0]);
        else if (d[6]) ;
        else if (d[5]) begin m_dl = d[4]; m_n = d[3]; end
        else if (d[4]) begin if (!d[3]) m_ac = m_step(m_ac, m_n, d[2]); end
        else if (d[3]) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        else if (d[2]) m_inc = d[1];
        else if (d[1]) m_ac = 0;
        else if (d[0]) begin
            m_ac = 0; m_inc = 1;
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        end
        wait_idle();
    endtask

    task automatic do_dwrite(input logic [7:0] d);
        int idx;
        xfer(1'b1, 1'b0, d, rdv, oev);
        idx = m_index(m_ac, m_n);
        if (idx >= 0) m_mem[idx] = d;
        else m_err_addr = 1;
        m_ac = m_step(m_ac, m_n, m_inc);
        wait_idle();
    endtask

    task automatic do_dread();
        int idx;
        xfer(1'b1, 1'b1, 8'h00, rdv, oev);
        idx = m_index(m_ac, m_n);
        check("dread_data", rdv, (idx >= 0) ? m_mem[idx] : 8'h20);
        check("dread_oe", oev, 1);
        m_ac = m_step(m_ac, m_n, m_inc);
    endtask

    task automatic peek(input int idx, output logic [7:0] v);
        rd_addr = 7'(idx);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic check_state(input string tag);
        check($sformatf("%s_ac", tag), ac, m_ac);
        check($sformatf("%s_entry", tag), entry_id, m_inc);
        check($sformatf("%s_func_n", tag), func_n, m_n);
        check($sformatf("%s_func_dl", tag), func_dl, m_dl);
        check($sformatf("%s_disp", tag), {disp_on, cur_on, blink_on}, {m_disp, m_cur, m_blink});
        check($sformatf("%s_err_addr", tag), err_addr, m_err_addr);
        check($sformatf("%s_err_busy", tag), err_busy, m_err_busy);
    endtask

    task automatic check_mem(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 80; i++) begin
            peek(i, v);
            check($sformatf("%s_mem%0d", tag, i), v, m_mem[i]);
        end
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int k, op;
        m_reset();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'hxx;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ac", ac, 0);
        check("rst_out", {lcd_data_oe, lcd_data_out}, 9'h000);
        check("rst_rd_data", rd_data, 8'h00);
        check_state("rst");
        resetn = 1'b1;
        @(negedge clk);

        // Initialisation sequence
        do_instr(8'h38); do_instr(8'h38); do_instr(8'h0E);
        do_instr(8'h06); do_instr(8'h02); do_instr(8'h01);
        check("init_flags", {func_n, disp_on, cur_on, entry_id}, 4'hF);
        check_state("init");
        check_mem("init");
        peek(100, v);
        check("rd_oob_space", v, 8'h20);

        // "Text" at line 0 start
        do_instr(8'h80);
        do_dwrite(8'h54); do_dwrite(8'h65); do_dwrite(8'h78); do_dwrite(8'h74);
        check("text_ac", ac, 7'h04);
        peek(0, v); check("text0", v, 8'h54);
        peek(3, v); check("text3", v, 8'h74);

        // Line 0 end wraps to line 1
        do_instr(8'hA7);
        do_dwrite(8'h41);
        check("wrap_ac", ac, 7'h40);
        do_dwrite(8'h42);
        peek(39, v); check("wrap_idx39", v, 8'h41);
        peek(40, v); check("wrap_idx40", v, 8'h42);

        // Invalid AC in 2-line mode
        do_instr(8'hA8);
        do_dwrite(8'h53);
        check("inv_err_addr", err_addr, 1);
        check("inv_ac", ac, 7'h29);
        check_state("inv");
        check_mem("inv");

        // Write while busy, then status read during busy
        do_instr(8'h80);
        xfer(1'b1, 1'b0, 8'h11, rdv, oev);
        m_mem[0] = 8'h11; m_ac = m_step(m_ac, m_n, m_inc);
        xfer(1'b1, 1'b0, 8'h99, rdv, oev);
        m_err_busy = 1;
        check("busy_err", err_busy, 1);
        xfer(1'b0, 1'b1, 8'h00, rdv, oev);
        check("busy_status", rdv, {1'b1, 7'(m_ac)});
        check("busy_status_oe", oev, 1);
        wait_idle();
        check_state("busyerr");
        peek(0, v); check("busy_ignored", v, 8'h11);

        // Data read advances AC
        do_instr(8'h82);
        do_dread();
        check("dread_ac", ac, 7'h03);

        // Randomised operations against the model
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: do_instr(8'h80 | 8'($urandom_range(0, 127)));
                1: do_instr(8'h04 | (8'($urandom_range(0, 1)) << 1));
                2: do_instr(8'h10 | (8'($urandom_range(0, 3)) << 2));
                3: do_instr($urandom_range(0, 3) == 0 ? 8'h30 : 8'h38);
                4: do_instr(8'h08 | 8'($urandom_range(0, 7)));
                5: do_dread();
                default: do_dwrite(8'($urandom_range(0, 255)));
            endcase
            check_state($sformatf("rnd%0d", it));
        end
        check_mem("rnd");

        // Reset in the middle of a clear
        do_instr(8'h38);
        do_instr(8'h9C); do_dwrite(8'hA5);
        do_instr(8'h9E); do_dwrite(8'hA5);
        do_instr(8'hE7); do_dwrite(8'hA5);
        xfer(1'b0, 1'b0, 8'h01, rdv, oev);
        rd_addr = 7'd28;
        k = 0;
        @(negedge clk);
        while (rd_data !== 8'h20 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("fill_reached_28", rd_data, 8'h20);
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 30; i++) m_mem[i] = 8'h20;
        m_reset();
        check("midfill_busy", busy, 0);
        check("midfill_ac", ac, 0);
        check_state("midfill");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        peek(30, v); check("midfill_idx30", v, 8'hA5);
        peek(79, v); check("midfill_idx79", v, 8'hA5);
        check_mem("midfill");
        check("midfill_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
